// File: rtl/cla_seq_ctrl.sv
// ============================================================================
// Module  : cla_seq_ctrl
// Brief   : Nibble-serial adder sequencer driving an external registered 4-bit CLA.
//           Optional subtract mode is enabled by the CLA_SEQ_SUB_EN macro.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module cla_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [4*NIBBLES-1:0] a,
    input  logic [4*NIBBLES-1:0] b,
    input  logic                 cin,
`ifdef CLA_SEQ_SUB_EN
    input  logic                 sub,
`endif
    output logic                 busy,
    output logic                 done,
    output logic [4*NIBBLES-1:0] sum,
    output logic                 cout,
    output logic                 cla_en,
    output logic [3:0]           cla_a,
    output logic [3:0]           cla_b,
    output logic                 cla_cin,
    input  logic [4:0]           cla_q
);

    localparam int IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_CAPT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t               state_q, state_d;
    logic [IDX_W-1:0]     idx_q;
    logic                 carry_q;
    logic [4*NIBBLES-1:0] a_q;
    logic [4*NIBBLES-1:0] b_q;
    logic [4*NIBBLES-1:0] sum_q;
    logic                 cout_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        idx_q <= '0;
`ifdef CLA_SEQ_SUB_EN
                        // Subtraction as a + ~b + 1: the forced carry supplies the +1.
                        if (sub) begin
                            b_q     <= ~b;
                            carry_q <= 1'b1;
                        end else begin
                            b_q     <= b;
                            carry_q <= cin;
                        end
`else
                        b_q     <= b;
                        carry_q <= cin;
`endif
                    end
                end
                S_CAPT: begin
                    sum_q[{idx_q, 2'b00} +: 4] <= cla_q[3:0];
                    carry_q                    <= cla_q[4];
                    if (idx_q == C_LAST_IDX) begin
                        cout_q <= cla_q[4];
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d = state_q;
        cla_en  = 1'b0;
        cla_a   = 4'd0;
        cla_b   = 4'd0;
        cla_cin = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cla_en  = 1'b1;
                cla_a   = a_q[{idx_q, 2'b00} +: 4];
                cla_b   = b_q[{idx_q, 2'b00} +: 4];
                cla_cin = carry_q;
                state_d = S_CAPT;
            end
            S_CAPT: begin
                state_d = (idx_q == C_LAST_IDX) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);
    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

`default_nettype wire
